alu_operand_sequencer: RTL and testbench

- Sequential front-end for the combinational ALU datapath (bitwise and arithmetic units).
- Consumes a byte stream from the serial receive side in fixed order: operand A, operand B, opcode.
- Drives the registered ALU operands and opcode, captures the ALU result, and hands it to the serial transmit side with a start/busy handshake.
- Sits between the UART RX/TX pair and the ALU.

---
 rtl/alu_operand_sequencer_pkg.sv | 26 ++
 rtl/alu_operand_sequencer_if.sv | 31 +++
 rtl/alu_operand_sequencer.sv | 95 +++++++++
 tb/tb_alu_operand_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM state encoding,
// default widths and the opcode values understood by the external ALU.
package alu_operand_sequencer_pkg;

  localparam int N_DEF   = 8;
  localparam int OPW_DEF = 6;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EVAL    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam logic [OPW_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [OPW_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [OPW_DEF-1:0] OP_AND = 6'h24;
  localparam logic [OPW_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [OPW_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [OPW_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [OPW_DEF-1:0] OP_SRL = 6'h02;
  localparam logic [OPW_DEF-1:0] OP_NOR = 6'h27;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Bundle of the receive stream, ALU operand/result and transmit handshake
// signals around the operand sequencer.
interface alu_operand_sequencer_if #(
  parameter int N   = 8,
  parameter int OPW = 6
) ();

  logic [N-1:0]   i_rx_data;
  logic           i_rx_valid;
  logic [N-1:0]   i_alu_result;
  logic           i_tx_busy;
  logic [N-1:0]   o_alu_a;
  logic [N-1:0]   o_alu_b;
  logic [OPW-1:0] o_alu_op;
  logic [N-1:0]   o_tx_data;
  logic           o_tx_start;
  logic           o_busy;
  logic           o_overrun;

  // master: the sequencer itself; slave: the UART/ALU environment around it
  modport master (
    input  i_rx_data, i_rx_valid, i_alu_result, i_tx_busy,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_alu_result, i_tx_busy,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun
  );

endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode bytes from the receive stream, presents them to the
// external ALU, latches the result and hands it to the transmitter.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  alu_operand_sequencer_if.master bus
);

  state_t         state_reg, state_next;
  logic [N-1:0]   a_reg, a_next;
  logic [N-1:0]   b_reg, b_next;
  logic [OPW-1:0] op_reg, op_next;
  logic [N-1:0]   tx_data_reg, tx_data_next;
  logic           busy_seen_reg, busy_seen_next;
  logic           overrun_reg, overrun_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= WAIT_A;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      tx_data_reg   <= '0;
      busy_seen_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      op_reg        <= op_next;
      tx_data_reg   <= tx_data_next;
      busy_seen_reg <= busy_seen_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    op_next        = op_reg;
    tx_data_next   = tx_data_reg;
    busy_seen_next = busy_seen_reg;
    overrun_next   = overrun_reg;

    case (state_reg)
      WAIT_A: if (bus.i_rx_valid) begin
        a_next     = bus.i_rx_data;
        state_next = WAIT_B;
      end
      WAIT_B: if (bus.i_rx_valid) begin
        b_next     = bus.i_rx_data;
        state_next = WAIT_OP;
      end
      WAIT_OP: if (bus.i_rx_valid) begin
        op_next    = bus.i_rx_data[OPW-1:0];
        state_next = EVAL;
      end
      EVAL: begin
        tx_data_next = bus.i_alu_result;
        state_next   = SEND;
      end
      SEND: if (!bus.i_tx_busy) begin
        busy_seen_next = 1'b0;
        state_next     = WAIT_TX;
      end
      WAIT_TX: begin
        // Only a busy low that follows a busy high ends the frame.
        if (bus.i_tx_busy)
          busy_seen_next = 1'b1;
        else if (busy_seen_reg)
          state_next = WAIT_A;
      end
      default: state_next = WAIT_A;
    endcase

    if (bus.i_rx_valid && (state_reg == EVAL || state_reg == SEND || state_reg == WAIT_TX))
      overrun_next = 1'b1;
  end

  // Start is decoded from state so an asynchronous reset drops it at once.
  assign bus.o_tx_start = (state_reg == SEND) && !bus.i_tx_busy;
  assign bus.o_busy     = (state_reg != WAIT_A);
  assign bus.o_overrun  = overrun_reg;
  assign bus.o_alu_a    = a_reg;
  assign bus.o_alu_b    = b_reg;
  assign bus.o_alu_op   = op_reg;
  assign bus.o_tx_data  = tx_data_reg;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for the operand sequencer with a behavioural ALU and a
// simple transmitter that stays busy for four cycles after each start.
module tb_alu_operand_sequencer;
  import alu_operand_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_hold = 1'b0;
  logic [3:0] tx_cnt;
  int total = 0;
  int bad = 0;
  int start_cnt = 0;

  alu_operand_sequencer_if #(.N(8), .OPW(6)) bus ();

  alu_operand_sequencer #(.N(8), .OPW(6)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRL:  return a >> b[2:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  always_comb bus.i_alu_result = alu_model(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tx_cnt <= 4'd0;
    else if (bus.o_tx_start)
      tx_cnt <= 4'd4;
    else if (tx_cnt != 4'd0)
      tx_cnt <= tx_cnt - 4'd1;
  end

  assign bus.i_tx_busy = (tx_cnt != 4'd0) | busy_hold;

  always @(posedge clk) if (bus.o_tx_start) start_cnt++;

  // Callers are always positioned at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  // Returns at the first falling edge with the sequencer back in WAIT_A.
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_busy && n < 100);
    total++;
    if (bus.o_busy) begin
      bad++;
      $display("FAIL wait_idle: o_busy still %b after %0d cycles, required 0", bus.o_busy, n);
    end
  endtask

  task automatic test_reset();
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.o_alu_a, bus.o_alu_b, bus.o_tx_data} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data: a=%h b=%h tx=%h, required 00", bus.o_alu_a, bus.o_alu_b, bus.o_tx_data);
    end
    total++;
    if (bus.o_alu_op !== 6'h00) begin
      bad++;
      $display("FAIL reset_op: got %h, required 00", bus.o_alu_op);
    end
    total++;
    if ({bus.o_tx_start, bus.o_busy, bus.o_overrun} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: start/busy/ovr=%b%b%b, required 000",
               bus.o_tx_start, bus.o_busy, bus.o_overrun);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_and_latency();
    int base;
    base = start_cnt;
    send_seq(8'hF0, 8'h3C, 8'h24);
    total++;
    if (bus.o_alu_op !== 6'h24) begin
      bad++;
      $display("FAIL and_op: got %h, required 24", bus.o_alu_op);
    end
    total++;
    if (bus.o_tx_start !== 1'b0) begin
      bad++;
      $display("FAIL and_start_early: got %b one cycle after OP, required 0", bus.o_tx_start);
    end
    @(negedge clk);
    total++;
    if (bus.o_tx_start !== 1'b1) begin
      bad++;
      $display("FAIL and_start: got %b two cycles after OP, required 1", bus.o_tx_start);
    end
    total++;
    if (bus.o_tx_data !== 8'h30) begin
      bad++;
      $display("FAIL and_result: got %h, required 30", bus.o_tx_data);
    end
    @(negedge clk);
    total++;
    if (bus.o_tx_start !== 1'b0) begin
      bad++;
      $display("FAIL and_start_width: got %b after pulse, required 0", bus.o_tx_start);
    end
    wait_idle();
    total++;
    if (start_cnt - base !== 1) begin
      bad++;
      $display("FAIL and_pulses: got %0d, required 1", start_cnt - base);
    end
    $display("and F0&3C: tx_data=%h", bus.o_tx_data);
  endtask

  task automatic test_op_mask();
    send_seq(8'h05, 8'h03, 8'hE0);
    total++;
    if (bus.o_alu_op !== 6'h20) begin
      bad++;
      $display("FAIL mask_op: got %h, required 20", bus.o_alu_op);
    end
    @(negedge clk);
    total++;
    if (bus.o_tx_data !== 8'h08 || bus.o_tx_start !== 1'b1) begin
      bad++;
      $display("FAIL mask_result: tx=%h start=%b, required 08/1", bus.o_tx_data, bus.o_tx_start);
    end
    wait_idle();
    $display("add op E0: tx_data=%h", bus.o_tx_data);
  endtask

  task automatic test_busy_hold();
    int base;
    base = start_cnt;
    send_byte(8'h12);
    send_byte(8'h34);
    busy_hold = 1'b1;
    send_byte(8'h25);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (bus.o_tx_start !== 1'b0) begin
        bad++;
        $display("FAIL hold_start: cycle %0d got %b, required 0", i, bus.o_tx_start);
      end
    end
    total++;
    if (bus.o_tx_data !== 8'h36) begin
      bad++;
      $display("FAIL hold_data: got %h, required 36", bus.o_tx_data);
    end
    busy_hold = 1'b0;
    #1;
    total++;
    if (bus.o_tx_start !== 1'b1) begin
      bad++;
      $display("FAIL hold_release: got %b, required 1", bus.o_tx_start);
    end
    @(negedge clk);
    total++;
    if (bus.o_tx_start !== 1'b0 || bus.o_tx_data !== 8'h36) begin
      bad++;
      $display("FAIL hold_after: start=%b tx=%h, required 0/36", bus.o_tx_start, bus.o_tx_data);
    end
    wait_idle();
    total++;
    if (start_cnt - base !== 1) begin
      bad++;
      $display("FAIL hold_pulses: got %0d, required 1", start_cnt - base);
    end
    $display("busy hold: tx_data=%h pulses=%0d", bus.o_tx_data, start_cnt - base);
  endtask

  task automatic test_overrun();
    send_seq(8'h11, 8'h22, 8'h26);
    @(negedge clk);
    send_byte(8'hAA);
    total++;
    if (bus.o_overrun !== 1'b1 || bus.o_busy !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set: overrun=%b busy=%b, required 1/1", bus.o_overrun, bus.o_busy);
    end
    wait_idle();
    total++;
    if (bus.o_tx_data !== 8'h33 || bus.o_overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_first: tx=%h overrun=%b, required 33/1", bus.o_tx_data, bus.o_overrun);
    end
    send_seq(8'h10, 8'h01, 8'h22);
    @(negedge clk);
    total++;
    if (bus.o_tx_data !== 8'h0F || bus.o_tx_start !== 1'b1) begin
      bad++;
      $display("FAIL ovr_next_seq: tx=%h start=%b, required 0F/1", bus.o_tx_data, bus.o_tx_start);
    end
    wait_idle();
    total++;
    if (bus.o_overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky: got %b, required 1", bus.o_overrun);
    end
    $display("overrun: overrun=%b tx_data=%h", bus.o_overrun, bus.o_tx_data);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h55);
    send_byte(8'h66);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.o_alu_a, bus.o_alu_b, bus.o_tx_data} !== 24'h0 || bus.o_alu_op !== 6'h00) begin
      bad++;
      $display("FAIL midrst_data: a=%h b=%h op=%h tx=%h, required all 0",
               bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data);
    end
    total++;
    if ({bus.o_tx_start, bus.o_busy, bus.o_overrun} !== 3'b000) begin
      bad++;
      $display("FAIL midrst_flags: start/busy/ovr=%b%b%b, required 000",
               bus.o_tx_start, bus.o_busy, bus.o_overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_seq(8'h0F, 8'hFF, 8'h25);
    @(negedge clk);
    total++;
    if (bus.o_tx_data !== 8'hFF || bus.o_tx_start !== 1'b1) begin
      bad++;
      $display("FAIL midrst_seq: tx=%h start=%b, required FF/1", bus.o_tx_data, bus.o_tx_start);
    end
    wait_idle();
    $display("reset mid-sequence: tx_data=%h", bus.o_tx_data);
  endtask

  task automatic test_back_to_back();
    int base;
    base = start_cnt;
    send_seq(8'h07, 8'h09, 8'h20);
    @(negedge clk);
    total++;
    if (bus.o_tx_data !== 8'h10 || bus.o_tx_start !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: tx=%h start=%b, required 10/1", bus.o_tx_data, bus.o_tx_start);
    end
    wait_idle();
    send_seq(8'hC0, 8'h0C, 8'h27);
    @(negedge clk);
    total++;
    if (bus.o_tx_data !== 8'h33 || bus.o_tx_start !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: tx=%h start=%b, required 33/1", bus.o_tx_data, bus.o_tx_start);
    end
    wait_idle();
    total++;
    if (bus.o_overrun !== 1'b0 || start_cnt - base !== 2) begin
      bad++;
      $display("FAIL b2b_final: overrun=%b pulses=%0d, required 0/2", bus.o_overrun, start_cnt - base);
    end
    $display("back-to-back: pulses=%0d overrun=%b", start_cnt - base, bus.o_overrun);
  endtask

  initial begin
    test_reset();
    test_and_latency();
    test_op_mask();
    test_busy_hold();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
